// File: rtl/cpu_dbg_pkg.sv
// Shared debug definitions: the halt instruction encoding and the run-controller state encodings.
package cpu_dbg_pkg;

    localparam logic [31:0] HALT_INST = 32'h00100073;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_RUN  = 2'd1,
        RS_STEP = 2'd2,
        RS_HALT = 2'd3
    } run_state_t;

endpackage

// File: rtl/dbg_counter.sv
// Wrapping event counter with increment enable; cleared only by the active-low reset.
module dbg_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt controller producing the CPU enable, with PC breakpoint and halt-instruction stop.
// Optional cycle watchdog enabled by defining RUN_CTRL_WATCHDOG_EN.
module cpu_run_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int          CNT_WIDTH  = 32,
    parameter logic [31:0] MAX_CYCLES = 32'd1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_req,
    input  logic                 step_req,
    input  logic                 stop_req,
    input  logic                 bp_en,
    input  logic [31:0]          bp_pc,
    input  logic [31:0]          cpu_pc,
    input  logic [31:0]          cpu_inst,
    output logic                 global_en,
    output logic [1:0]           run_state,
    output logic                 halted,
    output logic                 bp_hit,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] inst_cnt
);

    run_state_t state_reg, state_next;
    logic       bp_skip_reg, bp_skip_next;
    logic       en_d_reg;
    logic       bp_hit_reg;
    logic       bp_stop;
    logic       wd_stop;
    logic       wd_expire;
    logic       halt_now;
    logic       bp_match;

    assign halt_now = (cpu_inst == HALT_INST);
    assign bp_match = bp_en && (cpu_pc == bp_pc) && !bp_skip_reg;

    always_comb begin
        state_next = state_reg;
        global_en  = 1'b0;
        bp_stop    = 1'b0;
        wd_stop    = 1'b0;
        case (state_reg)
            RS_IDLE: begin
                if (run_req) begin
                    state_next = RS_RUN;
                end else if (step_req) begin
                    state_next = RS_STEP;
                end
            end
            RS_RUN: begin
                if (stop_req) begin
                    state_next = RS_IDLE;
                end else if (bp_match) begin
                    state_next = RS_IDLE;
                    bp_stop    = 1'b1;
                end else begin
                    // The halt instruction itself is allowed to commit before stopping.
                    global_en = 1'b1;
                    if (halt_now) begin
                        state_next = RS_HALT;
                    end else if (wd_expire) begin
                        state_next = RS_IDLE;
                        wd_stop    = 1'b1;
                    end
                end
            end
            RS_STEP: begin
                global_en  = 1'b1;
                state_next = halt_now ? RS_HALT : RS_IDLE;
            end
            RS_HALT: begin
                state_next = RS_HALT;
            end
            default: begin
                state_next = RS_IDLE;
            end
        endcase
    end

    // A resume must not re-trigger on the breakpoint it stopped at.
    always_comb begin
        bp_skip_next = bp_skip_reg;
        if (state_reg == RS_IDLE && run_req) begin
            bp_skip_next = 1'b1;
        end else if (global_en) begin
            bp_skip_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= RS_IDLE;
            bp_skip_reg <= 1'b0;
            en_d_reg    <= 1'b0;
            bp_hit_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bp_skip_reg <= bp_skip_next;
            en_d_reg    <= global_en;
            bp_hit_reg  <= bp_stop;
        end
    end

    dbg_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (global_en),
        .count (cycle_cnt)
    );

    // Instruction commits trail the enable by one cycle, matching the CPU's registered commit.
    dbg_counter #(.CNT_WIDTH(CNT_WIDTH)) u_inst_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (en_d_reg),
        .count (inst_cnt)
    );

`ifdef RUN_CTRL_WATCHDOG_EN
    logic timeout_reg;

    assign wd_expire = (cycle_cnt == CNT_WIDTH'(MAX_CYCLES - 32'd1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_reg <= 1'b0;
        end else if (wd_stop) begin
            timeout_reg <= 1'b1;
        end
    end

    assign timeout = timeout_reg;
`else
    logic unused_watchdog;

    assign wd_expire       = 1'b0;
    assign timeout         = 1'b0;
    assign unused_watchdog = ^{MAX_CYCLES, wd_stop};
`endif

    assign run_state = state_reg;
    assign halted    = (state_reg == RS_HALT);
    assign bp_hit    = bp_hit_reg;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Run/step/halt controller that generates the CPU's `global_en`. It sits directly upstream of the single-cycle CPU.
- Watches the CPU's current PC and instruction to stop on a PC breakpoint or on the halt instruction.
- Counts enabled cycles and committed instructions.
- Driven by the board debug/UART command layer.

Parameters:
- CNT_WIDTH, 32, width of cycle_cnt and inst_cnt.
- MAX_CYCLES, 32'd1000000, watchdog limit on cycle_cnt; used only with RUN_CTRL_WATCHDOG_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- run_req  in  1  single-cycle pulse: start free running.
- step_req  in  1  single-cycle pulse: execute exactly one instruction.
- stop_req  in  1  single-cycle pulse: stop free running.
- bp_en  in  1  breakpoint enable (level).
- bp_pc  in  32  breakpoint PC.
- cpu_pc  in  32  CPU current PC (the CPU's imem_raddr).
- cpu_inst  in  32  CPU current instruction (imem_rdata).
- global_en  out  1  CPU enable; combinational from state and inputs.
- run_state  out  2  IDLE=0, RUN=1, STEP=2, HALT=3.
- halted  out  1  high while in HALT.
- bp_hit  out  1  one-cycle pulse when a breakpoint stops RUN.
- timeout  out  1  sticky watchdog flag; constant 0 without the macro.
- cycle_cnt  out  CNT_WIDTH  number of cycles with global_en=1.
- inst_cnt  out  CNT_WIDTH  number of committed instructions.

Behaviour:
- Reset (rst=0, async):
  - state IDLE; global_en 0.
  - cycle_cnt, inst_cnt, bp_hit, timeout, en_d, bp_skip all 0.
- Definitions:
  - halt_now = (cpu_inst == HALT_INST).
  - bp_match = bp_en & (cpu_pc == bp_pc) & ~bp_skip.
- global_en: 1 when state==STEP, or when state==RUN & ~stop_req & ~bp_match. Otherwise 0.
- IDLE:
  - run_req → RUN; sets bp_skip=1 so a resume from the breakpoint PC executes that instruction.
  - else step_req → STEP.
  - run_req beats step_req when both arrive together; stop_req is ignored.
- RUN, priority order:
  1. stop_req → IDLE; global_en 0 this cycle.
  2. bp_match → IDLE; bp_hit pulses 1 next cycle; global_en 0 this cycle; PC is held at bp_pc.
  3. halt_now → HALT; global_en 1 this cycle so the halt instruction commits.
  4. otherwise stay in RUN.
  - run_req and step_req are ignored in RUN.
- STEP:
  - Lasts exactly one cycle with global_en=1.
  - Next state is HALT if halt_now, else IDLE.
  - Breakpoints are not checked; all requests are ignored.
- HALT: absorbing; all requests ignored; exit only by reset. halted=1.
- bp_skip: cleared on the first cycle global_en=1 after being set.
- Commit tracking:
  - en_d <= global_en.
  - inst_cnt += 1 on every cycle with en_d=1. This matches the CPU's one-cycle registered commit outputs.
- cycle_cnt += 1 on every cycle with global_en=1.
- Both counters wrap modulo 2^CNT_WIDTH without saturation and are never cleared except by reset.
- Reset asserted mid-RUN: immediate return to IDLE; global_en drops asynchronously.

Optional Feature:
- Macro: RUN_CTRL_WATCHDOG_EN.
- Defined:
  - In RUN, if cycle_cnt == MAX_CYCLES-1 and global_en=1, the next state is IDLE and timeout is set (sticky until reset).
  - stop_req, bp_match and halt_now take priority in the same cycle.
  - STEP is unaffected.
- Undefined: no comparator; timeout tied to 0; MAX_CYCLES unused.

Decomposition:
- Shared package `cpu_dbg_pkg`:
  - HALT_INST = 32'h00100073, also used by the CPU's commit_halt logic.
  - run-state encodings RS_IDLE/RS_RUN/RS_STEP/RS_HALT.
- One sub-module, `dbg_counter`: CNT_WIDTH wrapping counter with async active-low reset and increment enable. Instantiated twice (cycle, instruction).

Test Plan:
- Reset, then step_req at t0 with cpu_inst=32'h00000013 → global_en=1 for exactly one cycle; state IDLE afterwards; cycle_cnt=1; inst_cnt=1 one cycle later.
- run_req, let 10 cycles pass, then stop_req → global_en high 10 cycles and low on the stop cycle; cycle_cnt=10; state IDLE.
- bp_en=1, bp_pc=32'h0000_0010, RUN from PC 0 with PC advancing by 4 per enabled cycle → stop with cpu_pc=0x10; bp_hit pulses once; cycle_cnt=4. A second run_req executes 0x10 and continues.
- RUN reaches cpu_inst=32'h00100073 → global_en=1 on that cycle, then HALT with halted=1; later run_req/step_req give no global_en.
- run_req and step_req in the same cycle from IDLE → RUN. Assert rst=0 mid-RUN → global_en drops with no clock edge; all counters read 0.
- With RUN_CTRL_WATCHDOG_EN and MAX_CYCLES=8: run with no halt → exactly 8 enabled cycles, then IDLE with timeout=1, staying 1 after a further run_req.
